// File: rtl/store_buffer_if.sv
// Core/memory-side bundle for the store buffer.
// The slave modport belongs to the buffer; the master modport belongs to the core/memory environment.
interface store_buffer_if #(
  parameter int CW = 3
);
  logic          we;
  logic [31:0]   adr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          full;
  logic          overflow;
  logic [CW-1:0] count;
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_adr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_radr;
  logic [31:0]   mem_rdata;

  modport master (
    output we, adr, wdata, mem_ready, mem_rdata,
    input  rdata, full, overflow, count, mem_valid, mem_adr, mem_wdata, mem_radr
  );

  modport slave (
    input  we, adr, wdata, mem_ready, mem_rdata,
    output rdata, full, overflow, count, mem_valid, mem_adr, mem_wdata, mem_radr
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between core and backing memory, with
// youngest-match load forwarding and a sticky overflow flag.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          pop;
  logic          push;
  logic [PW-1:0] slot;
  logic [31:0]   fwd;

  // Entries hold the word address only; the byte offset is always zero.
  logic [29:0] word_q [DEPTH];
  logic [31:0] data_q [DEPTH];

  assign pop  = (count_q != '0) & bus.mem_ready;
  assign push = bus.we & ((count_q < FULL_CNT) | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)
        head <= head + PW'(1);
      if (push)
        tail <= tail + PW'(1);
      if (push & ~pop)
        count_q <= count_q + CW'(1);
      else if (pop & ~push)
        count_q <= count_q - CW'(1);
      if (bus.we & ~push)
        overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_q[tail] <= bus.adr[31:2];
      data_q[tail] <= bus.wdata;
    end
  end

  // Walk oldest to youngest over valid slots so the last hit is the youngest store.
  always_comb begin
    fwd  = bus.mem_rdata;
    slot = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if ((CW'(i) < count_q) && (word_q[slot] == bus.adr[31:2]))
        fwd = data_q[slot];
    end
  end

  assign bus.rdata     = fwd;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == FULL_CNT);
  assign bus.overflow  = overflow_q;
  assign bus.mem_valid = (count_q != '0);
  assign bus.mem_adr   = {word_q[head], 2'b00};
  assign bus.mem_wdata = data_q[head];
  assign bus.mem_radr  = bus.adr;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if #(.CW(CW)) bus();
  store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] m_fwd(input logic [31:0] a, input logic [31:0] mr);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == {a[31:2], 2'b00}) return q[i].d;
    return mr;
  endfunction

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bus.we = w; bus.adr = a; bus.wdata = d; bus.mem_ready = rdy;
  endtask

  // One rising edge; the model applies the buffer rules to the inputs held across it.
  task automatic tick();
    bit pop, acc;
    pop = (q.size() != 0) && bus.mem_ready;
    acc = bus.we && ((q.size() < DEPTH) || pop);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{{bus.adr[31:2], 2'b00}, bus.wdata});
    else if (bus.we) m_ovf = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    q.delete(); m_ovf = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 32'h0000_0123, 0, 0);
    bus.mem_rdata = 32'hCAFE_F00D;
    #2;
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.count); end
    tests++; if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got %b want 0", bus.mem_valid); end
    tests++; if (bus.full !== 1'b0 || bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_flags got full=%b ovf=%b want 0/0", bus.full, bus.overflow); end
    tests++; if (bus.rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL reset_rdata got %h want cafef00d", bus.rdata); end
    tests++; if (bus.mem_radr !== 32'h0000_0123) begin fails++; $display("FAIL reset_mem_radr got %h want 00000123", bus.mem_radr); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 32'h64, 32'd25, 0);
    #1;
    tests++; if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL basic_latency got mem_valid=%b want 0", bus.mem_valid); end
    tick();
    drive(0, 0, 0, 0);
    tests++; if (bus.count !== 3'd1 || bus.mem_valid !== 1'b1) begin fails++; $display("FAIL basic_push got count=%0d valid=%b want 1/1", bus.count, bus.mem_valid); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.mem_adr !== 32'h64 || bus.mem_wdata !== 32'd25) begin
        fails++; $display("FAIL basic_hold cycle %0d got %h/%0d want 00000064/25", i, bus.mem_adr, bus.mem_wdata);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    tick();
    tests++; if (bus.count !== 3'd0 || bus.mem_valid !== 1'b0) begin fails++; $display("FAIL basic_drain got count=%0d valid=%b want 0/0", bus.count, bus.mem_valid); end
  endtask

  task automatic test_full_overflow_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'(i * 4), 32'(i + 10), 0);
      tick();
      if (i == 3) begin
        tests++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin fails++; $display("FAIL full_after4 got full=%b ovf=%b want 1/0", bus.full, bus.overflow); end
      end
    end
    tests++; if (bus.count !== 3'd4 || bus.overflow !== 1'b1) begin fails++; $display("FAIL overflow got count=%0d ovf=%b want 4/1", bus.count, bus.overflow); end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.mem_adr !== 32'(i * 4) || bus.mem_wdata !== 32'(i + 10)) begin
        fails++; $display("FAIL drain_order %0d got %h/%0d want %h/%0d", i, bus.mem_adr, bus.mem_wdata, i * 4, i + 10);
      end
      tick();
    end
    tests++; if (bus.count !== 3'd0 || bus.overflow !== 1'b1) begin fails++; $display("FAIL drained got count=%0d ovf=%b want 0/1", bus.count, bus.overflow); end
    // Second fill starts with both pointers wrapped back to slot 0; pop two then push two more to wrap again.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h20 + 32'(i * 4), 32'(i + 50), 0);
      tick();
    end
    drive(0, 0, 0, 1); tick(); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h40 + 32'(i * 4), 32'(i + 70), 0);
      tick();
    end
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL wrap_full got %b want 1", bus.full); end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ea;
      ea = (i < 2) ? 32'h28 + 32'(i * 4) : 32'h40 + 32'((i - 2) * 4);
      tests++;
      if (bus.mem_adr !== ea || bus.mem_adr !== q[0].a) begin
        fails++; $display("FAIL wrap_order %0d got %h want %h", i, bus.mem_adr, ea);
      end
      tick();
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h200 + 32'(i * 4), 32'(100 + i), 0);
      tick();
    end
    drive(1, 32'h40, 32'hAB, 1);
    tick();
    tests++; if (bus.count !== 3'd4 || bus.overflow !== 1'b0) begin fails++; $display("FAIL full_pop got count=%0d ovf=%b want 4/0", bus.count, bus.overflow); end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ea;
      ea = (i == 3) ? 32'h40 : 32'h204 + 32'(i * 4);
      tests++;
      if (bus.mem_adr !== ea) begin fails++; $display("FAIL full_pop_order %0d got %h want %h", i, bus.mem_adr, ea); end
      tick();
    end
  endtask

  task automatic test_forward();
    do_reset();
    drive(1, 32'h60, 32'd7, 0); tick();
    drive(1, 32'h60, 32'd9, 0); tick();
    bus.mem_rdata = 32'hDEAD;
    drive(0, 32'h62, 0, 0); #1;
    tests++; if (bus.rdata !== 32'd9) begin fails++; $display("FAIL fwd_youngest got %h want 9", bus.rdata); end
    drive(0, 32'h68, 0, 0); #1;
    tests++; if (bus.rdata !== 32'hDEAD) begin fails++; $display("FAIL fwd_miss got %h want dead", bus.rdata); end
    drive(1, 32'h60, 32'h55, 0); #1;
    tests++; if (bus.rdata !== 32'd9) begin fails++; $display("FAIL fwd_same_cycle_store got %h want 9", bus.rdata); end
    do_reset();
    drive(1, 32'h70, 32'd3, 0); tick();
    drive(0, 32'h71, 0, 1); #1;
    tests++; if (bus.rdata !== 32'd3) begin fails++; $display("FAIL fwd_pop_cycle got %h want 3", bus.rdata); end
    tick();
    tests++; if (bus.rdata !== 32'hDEAD) begin fails++; $display("FAIL fwd_after_pop got %h want dead", bus.rdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(i * 4), 32'(i), 0);
      tick();
    end
    drive(0, 0, 0, 1);
    #2;
    reset = 1'b1;
    q.delete(); m_ovf = 1'b0;
    #1;
    tests++; if (bus.mem_valid !== 1'b0 || bus.count !== 3'd0) begin fails++; $display("FAIL reset_mid got valid=%b count=%0d want 0/0", bus.mem_valid, bus.count); end
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    tests++; if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL reset_mid_after got valid=%b want 0", bus.mem_valid); end
  endtask

  task automatic test_stale();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h80 + 32'(i * 4), 32'h900 + 32'(i), 0);
      tick();
    end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick();
    bus.mem_rdata = 32'h1234;
    drive(0, 32'h84, 0, 0); #1;
    tests++; if (bus.rdata !== 32'h1234) begin fails++; $display("FAIL stale_slot got %h want 1234", bus.rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      drive(($urandom_range(0, 9) < 6), a, $urandom, ($urandom_range(0, 1) == 1));
      bus.mem_rdata = $urandom;
      #1;
      tests++;
      if (bus.rdata !== m_fwd(a, bus.mem_rdata) || bus.mem_radr !== a) begin
        fails++; $display("FAIL rand_fwd n=%0d got %h want %h", n, bus.rdata, m_fwd(a, bus.mem_rdata));
      end
      tick();
      tests++;
      if (bus.count !== CW'(q.size()) || bus.mem_valid !== (q.size() != 0) ||
          bus.full !== (q.size() == DEPTH) || bus.overflow !== m_ovf) begin
        fails++; $display("FAIL rand_state n=%0d got cnt=%0d v=%b f=%b o=%b want cnt=%0d o=%b",
                          n, bus.count, bus.mem_valid, bus.full, bus.overflow, q.size(), m_ovf);
      end
      if (q.size() != 0) begin
        tests++;
        if (bus.mem_adr !== q[0].a || bus.mem_wdata !== q[0].d) begin
          fails++; $display("FAIL rand_head n=%0d got %h/%h want %h/%h", n, bus.mem_adr, bus.mem_wdata, q[0].a, q[0].d);
        end
      end
    end
  endtask

  initial begin
    bus.mem_rdata = 0;
    drive(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_full_overflow_wrap();
    test_full_pop();
    test_forward();
    test_reset_mid();
    test_stale();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
